bk_stream_accumulator: RTL and testbench

//  Packet accumulator that sits directly downstream of the 32-bit brent_kung adder and consumes its sum.

---
 rtl/bk_stream_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_bk_stream_accumulator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_stream_accumulator.sv
// Packet accumulator: sums 32-bit beats per in_last-framed packet via a Brent-Kung adder; BK_ACC_SAT_EN saturates on carry.
// Latency: result valid from the edge that accepts the last beat; N-beat packet occupies N+1 cycles.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready.

module brent_kung (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    // Level 0 holds bitwise generate/propagate; levels 1-5 are the up-sweep
    // (strides 1..16), levels 6-9 the down-sweep filling the remaining prefixes.
    wire [31:0] g_lvl [0:9];
    wire [31:0] p_lvl [0:9];

    assign g_lvl[0] = a & b;
    assign p_lvl[0] = a ^ b;

    genvar l, i;
    generate
        for (l = 0; l < 5; l++) begin : g_up
            for (i = 0; i < 32; i++) begin : g_bit
                if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
                    assign g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(2**l)]);
                    assign p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(2**l)];
                end else begin : g_pass
                    assign g_lvl[l+1][i] = g_lvl[l][i];
                    assign p_lvl[l+1][i] = p_lvl[l][i];
                end
            end
        end

        for (l = 3; l >= 0; l--) begin : g_down
            for (i = 0; i < 32; i++) begin : g_bit
                if ((((i + 1) % (2 ** (l + 1))) == (2 ** l)) && (i >= (2 ** (l + 1)))) begin : g_node
                    assign g_lvl[9-l][i] = g_lvl[8-l][i] | (p_lvl[8-l][i] & g_lvl[8-l][i-(2**l)]);
                    assign p_lvl[9-l][i] = p_lvl[8-l][i] & p_lvl[8-l][i-(2**l)];
                end else begin : g_pass
                    assign g_lvl[9-l][i] = g_lvl[8-l][i];
                    assign p_lvl[9-l][i] = p_lvl[8-l][i];
                end
            end
        end

        // g_lvl[9][i] is the carry out of bits [i:0]; there is no carry-in.
        assign sum[0] = p_lvl[0][0];
        for (i = 1; i < 32; i++) begin : g_sum
            assign sum[i] = p_lvl[0][i] ^ g_lvl[9][i-1];
        end
    endgenerate
endmodule

module bk_stream_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic               out_valid_nxt;
    logic [31:0]        out_data_nxt;
    logic [CNT_W-1:0]   out_count_nxt;
    logic               out_ovf_nxt;

    logic [31:0]        add_a;
    logic [31:0]        add_sum;
    logic               carry;
    logic               beat;
    logic [31:0]        acc_add;

    assign in_ready = ~rst & (state != HOLD);
    assign beat     = in_valid & in_ready;

    // The first beat of a packet starts from zero rather than the stale total.
    assign add_a = (state == ACCUM) ? acc : 32'd0;

    brent_kung u_adder (
        .a   (add_a),
        .b   (in_data),
        .sum (add_sum)
    );

    assign carry = (add_a[31] & in_data[31]) | ((add_a[31] ^ in_data[31]) & ~add_sum[31]);

`ifdef BK_ACC_SAT_EN
    assign acc_add = carry ? 32'hFFFF_FFFF : add_sum;
`else
    assign acc_add = add_sum;
`endif

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;
        out_ovf_nxt   = out_ovf;

        case (state)
            IDLE: begin
                if (beat) begin
                    acc_nxt   = add_sum;
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_nxt   = acc_add;
                    cnt_nxt   = (&cnt) ? cnt : cnt + CNT_W'(1);
                    ovf_nxt   = ovf | carry;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt     = IDLE;
                    acc_nxt       = 32'd0;
                    cnt_nxt       = '0;
                    ovf_nxt       = 1'b0;
                    out_valid_nxt = 1'b0;
                    out_data_nxt  = 32'd0;
                    out_count_nxt = '0;
                    out_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Result registers load on the same edge that accepts the last beat.
        if ((state != HOLD) && (state_nxt == HOLD)) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = acc_nxt;
            out_count_nxt = cnt_nxt;
            out_ovf_nxt   = ovf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
            out_ovf   <= out_ovf_nxt;
        end
    end
endmodule

// File: tb/tb_bk_stream_accumulator.sv
// Randomized scoreboard bench for bk_stream_accumulator; a wide-counter and a 2-bit-counter instance share one input stream.
module tb_bk_stream_accumulator;
    localparam int CNT_W  = 8;
    localparam int CNT_W2 = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_last;
    logic [31:0]       in_data;
    logic              out_ready;

    logic              in_ready, out_valid, out_ovf;
    logic [31:0]       out_data;
    logic [CNT_W-1:0]  out_count;
    logic              in_ready2, out_valid2, out_ovf2;
    logic [31:0]       out_data2;
    logic [CNT_W2-1:0] out_count2;

    always #5 clk = ~clk;

    bk_stream_accumulator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    bk_stream_accumulator #(.CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2), .out_ovf(out_ovf2)
    );

    typedef struct {
        logic [31:0] data;
        int          beats;
        logic        ovf;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              ready_mode = 0;
    bit              started = 0;
    longint unsigned m_sum = 0;
    int              m_beats = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the exact packet total decides everything; any carry out of
    // bit 31 means the true total reached 2^32.
    function automatic exp_t model(input longint unsigned total, input int beats);
        exp_t e;
        e.beats = beats;
        e.ovf   = (total >= 64'h1_0000_0000);
`ifdef BK_ACC_SAT_EN
        e.data  = e.ovf ? 32'hFFFF_FFFF : total[31:0];
`else
        e.data  = total[31:0];
`endif
        return e;
    endfunction

    function automatic int sat_cnt(input int beats, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (beats > mx) ? mx : beats;
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 1000));
            1:       return $urandom;
            default: return 32'hF000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
        endcase
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok;
        int waited;
        ok = 0;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) begin
                waited++;
                if (waited > 500) begin
                    check("beat_accept_timeout", 64'(waited), 64'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_sum   += 64'(d);
        m_beats++;
        if (l) begin
            sb.push_back(model(m_sum, m_beats));
            m_sum   = 0;
            m_beats = 0;
            check("out_valid_after_last", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 2;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each presented result with the scoreboard head.
    initial begin
        logic              prev_hs, prev_stall, prev_ovf;
        logic [31:0]       prev_data;
        logic [CNT_W-1:0]  prev_cnt;
        exp_t              e;
        prev_hs = 0; prev_stall = 0; prev_ovf = 0; prev_data = 0; prev_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !started) begin
                prev_hs = 0;
                prev_stall = 0;
            end else begin
                if (prev_hs) check("out_valid_drops", 64'(out_valid), 64'd0);
                if (prev_stall) begin
                    check("stall_data_stable", 64'(out_data), 64'(prev_data));
                    check("stall_count_stable", 64'(out_count), 64'(prev_cnt));
                    check("stall_ovf_stable", 64'(out_ovf), 64'(prev_ovf));
                end
                if (out_valid) begin
                    check("in_ready_low_in_hold", 64'(in_ready), 64'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb[0];
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_count", 64'(out_count), 64'(sat_cnt(e.beats, CNT_W)));
                        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
                        check("dut2_valid", 64'(out_valid2), 64'd1);
                        check("dut2_data", 64'(out_data2), 64'(e.data));
                        check("dut2_count", 64'(out_count2), 64'(sat_cnt(e.beats, CNT_W2)));
                        check("dut2_ovf", 64'(out_ovf2), 64'(e.ovf));
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                prev_hs    = out_valid & out_ready;
                prev_stall = out_valid & ~out_ready;
                prev_data  = out_data;
                prev_cnt   = out_count;
                prev_ovf   = out_ovf;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1;

        // Directed: small packet, single beat, carry out of bit 31.
        ready_mode = 2;
        send_beat(32'd1, 1'b0); send_beat(32'd2, 1'b0); send_beat(32'd3, 1'b1);
        send_beat(32'hDEAD_BEEF, 1'b1);
        send_beat(32'hFFFF_FFFF, 1'b0); send_beat(32'd2, 1'b1);
        ready_mode = 0;
        send_beat(32'hFFFF_FFFF, 1'b0); send_beat(32'd2, 1'b0); send_beat(32'd9, 1'b1);

        // Result held with out_ready low while a new beat is offered.
        drain();
        ready_mode = 1;
        idle(1);
        send_beat(32'd1, 1'b0); send_beat(32'd2, 1'b0); send_beat(32'd3, 1'b1);
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("held_in_ready", 64'(in_ready), 64'd0);
            check("held_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        ready_mode = 2;
        send_beat(32'd7, 1'b1);

        // Five beats of 1 with gaps: 2-bit counter saturates at 3.
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            send_beat(32'd1, 1'(i == 4));
            if (i < 4) idle($urandom_range(1, 3));
        end

        // Reset in the middle of a packet discards it.
        drain();
        ready_mode = 0;
        send_beat(32'd11, 1'b0); send_beat(32'd22, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_dut2_valid", 64'(out_valid2), 64'd0);
        m_sum = 0; m_beats = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        send_beat(32'd5, 1'b1);

        // Long packet saturates the 8-bit counter.
        for (int i = 0; i < 300; i++)
            send_beat(32'($urandom_range(0, 10)), 1'(i == 299));

        // Random packets with random gaps and backpressure.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = (p % 10 == 0) ? $urandom_range(7, 12) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send_beat(pick_data(), 1'(i == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        drain();
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
